// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode constants, hazard-action encoding and operand
//                usage helpers for the pipeline controller and hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // Action taken by the hazard unit in a cycle; also the HazState encoding.
    typedef enum logic [1:0] {
        HAZ_RUN        = 2'd0,
        HAZ_LOAD_STALL = 2'd1,
        HAZ_FLUSH      = 2'd2,
        HAZ_FREEZE     = 2'd3
    } haz_state_t;

    // Only the absolute jumps ignore rs; any unknown opcode is assumed to read it.
    function automatic logic uses_rs(input logic [5:0] op);
        return !((op == c_OP_J) || (op == c_OP_JAL));
    endfunction

    // rt is a source only for R-type, compare-branches and stores.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_BEQ) || (op == c_OP_BNE) ||
               (op == c_OP_SW)    || (op == c_OP_SH)  || (op == c_OP_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : Bundle between pipeline datapath (master) and hazard unit
//                (slave): hazard inputs, pipeline controls and counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_unit_if;
    import mips_pkg::*;

    logic [31:0] ID_Instruction;
    logic        EX_MemRead;
    logic [4:0]  EX_Rt;
    logic        EX_BranchTaken;
    logic        MemBusy;
    logic        ClearCounters;

    logic        PCWrite;
    logic        IFID_Write;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        Freeze;
    haz_state_t  HazState;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
    logic [15:0] FreezeCount;

    modport master (
        output ID_Instruction, EX_MemRead, EX_Rt, EX_BranchTaken, MemBusy, ClearCounters,
        input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze,
        input  HazState, StallCount, FlushCount, FreezeCount
    );

    modport slave (
        input  ID_Instruction, EX_MemRead, EX_Rt, EX_BranchTaken, MemBusy, ClearCounters,
        output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze,
        output HazState, StallCount, FlushCount, FreezeCount
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up counter that sticks at all-ones, with synchronous clear
//                taking precedence over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic [WIDTH-1:0]      o_count
);
    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count qualifying cycles; clear wins, and the value holds once saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Five-stage pipeline hazard control: memory freeze, branch
//                flush and single-cycle load-use stall, plus cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import mips_pkg::*;
(
    input  wire logic   Clk,
    input  wire logic   Rst,
    hazard_unit_if.slave hz
);
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_load_use;
    logic        w_unused_bits;
    haz_state_t  w_action;
    haz_state_t  r_haz_state;

    assign w_op          = hz.ID_Instruction[31:26];
    assign w_rs          = hz.ID_Instruction[25:21];
    assign w_rt          = hz.ID_Instruction[20:16];
    assign w_unused_bits = &{1'b0, hz.ID_Instruction[15:0]};

    // Load-use: the instruction in ID reads the register a load in EX will write.
    assign w_load_use = hz.EX_MemRead && (hz.EX_Rt != 5'd0) &&
                        ((uses_rs(w_op) && (w_rs == hz.EX_Rt)) ||
                         (uses_rt(w_op) && (w_rt == hz.EX_Rt)));

    // Pick this cycle's action by priority; a repeat of the same hazard right
    // after a stall is already covered by the bubble now sitting in EX.
    always_comb begin
        w_action = HAZ_RUN;
        if (hz.MemBusy) begin
            w_action = HAZ_FREEZE;
        end else if (hz.EX_BranchTaken) begin
            w_action = HAZ_FLUSH;
        end else if (w_load_use && (r_haz_state != HAZ_LOAD_STALL)) begin
            w_action = HAZ_LOAD_STALL;
        end
    end

    // Remember the previous action; reset discards any stall or freeze in progress.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_haz_state <= HAZ_RUN;
        end else begin
            r_haz_state <= w_action;
        end
    end

    // Decode the action into pipeline controls; reset forces a safe bubble.
    always_comb begin
        hz.PCWrite     = 1'b1;
        hz.IFID_Write  = 1'b1;
        hz.IDEX_Bubble = 1'b0;
        hz.IFID_Flush  = 1'b0;
        hz.IDEX_Flush  = 1'b0;
        hz.Freeze      = 1'b0;
        if (Rst) begin
            hz.PCWrite     = 1'b0;
            hz.IFID_Write  = 1'b0;
            hz.IDEX_Bubble = 1'b1;
        end else begin
            case (w_action)
                HAZ_FREEZE: begin
                    hz.Freeze     = 1'b1;
                    hz.PCWrite    = 1'b0;
                    hz.IFID_Write = 1'b0;
                end
                HAZ_FLUSH: begin
                    hz.IFID_Flush = 1'b1;
                    hz.IDEX_Flush = 1'b1;
                end
                HAZ_LOAD_STALL: begin
                    hz.PCWrite     = 1'b0;
                    hz.IFID_Write  = 1'b0;
                    hz.IDEX_Bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.HazState = r_haz_state;

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_inc   (w_action == HAZ_LOAD_STALL),
        .i_clr   (hz.ClearCounters),
        .o_count (hz.StallCount)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_inc   (w_action == HAZ_FLUSH),
        .i_clr   (hz.ClearCounters),
        .o_count (hz.FlushCount)
    );

    sat_counter #(.WIDTH(16)) u_freeze_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_inc   (w_action == HAZ_FREEZE),
        .i_clr   (hz.ClearCounters),
        .o_count (hz.FreezeCount)
    );
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed self-checking bench for hazard_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;
    logic Clk;
    logic Rst;
    int   n_tests;
    int   n_fail;

    hazard_unit_if hz ();

    hazard_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .hz  (hz.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Order: PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze
    task automatic outs(input string tag, input logic [5:0] exp);
        chk1({tag, ".PCWrite"},     hz.PCWrite,     exp[5]);
        chk1({tag, ".IFID_Write"},  hz.IFID_Write,  exp[4]);
        chk1({tag, ".IDEX_Bubble"}, hz.IDEX_Bubble, exp[3]);
        chk1({tag, ".IFID_Flush"},  hz.IFID_Flush,  exp[2]);
        chk1({tag, ".IDEX_Flush"},  hz.IDEX_Flush,  exp[1]);
        chk1({tag, ".Freeze"},      hz.Freeze,      exp[0]);
    endtask

    task automatic st(input string tag, input logic [1:0] exp);
        chk16({tag, ".HazState"}, {14'd0, hz.HazState}, {14'd0, exp});
    endtask

    task automatic drive(input logic [31:0] instr, input logic mr, input logic [4:0] ert,
                         input logic br, input logic busy, input logic clr);
        hz.ID_Instruction = instr;
        hz.EX_MemRead     = mr;
        hz.EX_Rt          = ert;
        hz.EX_BranchTaken = br;
        hz.MemBusy        = busy;
        hz.ClearCounters  = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [5:0] RUN_O   = 6'b110000;
    localparam logic [5:0] STALL_O = 6'b001000;
    localparam logic [5:0] FLUSH_O = 6'b110110;
    localparam logic [5:0] FRZ_O   = 6'b000001;
    localparam logic [5:0] RST_O   = 6'b001000;

    logic [31:0] add_t1_t0_t2;
    logic [31:0] nop;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        add_t1_t0_t2 = ins(6'h00, 5'd8, 5'd10);
        nop          = 32'h0000_0000;

        // Reset holds safe outputs even with memory busy
        Rst = 1'b1;
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        outs("reset", RST_O);
        tick();
        st("reset", 2'd0);
        chk16("reset.FreezeCount", hz.FreezeCount, 16'd0);
        chk16("reset.StallCount", hz.StallCount, 16'd0);
        chk16("reset.FlushCount", hz.FlushCount, 16'd0);

        Rst = 1'b0;
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        outs("run0", RUN_O);
        tick();
        st("run0", 2'd0);

        // lw $t0 in EX, add $t1,$t0,$t2 in ID: one stall then run
        drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("loaduse", STALL_O);
        tick();
        st("loaduse", 2'd1);
        chk16("loaduse.StallCount", hz.StallCount, 16'd1);
        outs("loaduse2", RUN_O);
        tick();
        st("loaduse2", 2'd0);
        chk16("loaduse2.StallCount", hz.StallCount, 16'd1);

        // $zero destination never stalls
        drive(ins(6'h00, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        outs("rt_zero", RUN_O);
        tick();
        // addi: rt is a destination, not a source
        drive(ins(6'h08, 5'd9, 5'd8), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("addi_rt", RUN_O);
        tick();
        // sw reads rt
        drive(ins(6'h2B, 5'd9, 5'd8), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("sw_rt", STALL_O);
        tick();
        chk16("sw_rt.StallCount", hz.StallCount, 16'd2);
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        st("gap1", 2'd0);
        // j ignores rs field
        drive(ins(6'h02, 5'd8, 5'd0), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("j_rs", RUN_O);
        tick();
        // unlisted opcode: rs used, rt not
        drive(ins(6'h3F, 5'd9, 5'd8), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("unl_rt", RUN_O);
        tick();
        drive(ins(6'h3F, 5'd8, 5'd9), 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("unl_rs", STALL_O);
        tick();
        chk16("unl_rs.StallCount", hz.StallCount, 16'd3);
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Branch taken beats load-use
        drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        outs("br_lu", FLUSH_O);
        tick();
        st("br_lu", 2'd2);
        chk16("br_lu.FlushCount", hz.FlushCount, 16'd1);
        chk16("br_lu.StallCount", hz.StallCount, 16'd3);

        // Freeze three cycles with a pending branch, flush on the fourth
        for (int i = 0; i < 3; i++) begin
            drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
            outs("freeze", FRZ_O);
            tick();
            st("freeze", 2'd3);
        end
        chk16("freeze.FreezeCount", hz.FreezeCount, 16'd3);
        drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        outs("post_frz", FLUSH_O);
        tick();
        st("post_frz", 2'd2);
        chk16("post_frz.FlushCount", hz.FlushCount, 16'd2);

        // Saturation of the stall counter
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        force dut.u_stall_cnt.r_count = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.r_count;
        tick();
        drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("sat1", STALL_O);
        tick();
        chk16("sat1.StallCount", hz.StallCount, 16'hFFFF);
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(add_t1_t0_t2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        outs("sat2", STALL_O);
        tick();
        chk16("sat2.StallCount", hz.StallCount, 16'hFFFF);

        // Clear overrides a same-cycle increment
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        st("clear", 2'd3);
        chk16("clear.StallCount", hz.StallCount, 16'd0);
        chk16("clear.FlushCount", hz.FlushCount, 16'd0);
        chk16("clear.FreezeCount", hz.FreezeCount, 16'd0);

        // Asynchronous reset in the middle of a freeze
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        st("pre_rst", 2'd3);
        chk16("pre_rst.FreezeCount", hz.FreezeCount, 16'd1);
        Rst = 1'b1;
        #1;
        outs("async_rst", RST_O);
        st("async_rst", 2'd0);
        chk16("async_rst.FreezeCount", hz.FreezeCount, 16'd0);
        tick();
        Rst = 1'b0;
        drive(nop, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        outs("rel", RUN_O);
        tick();
        st("rel", 2'd0);
        chk16("rel.FreezeCount", hz.FreezeCount, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
